// File: rtl/wheel_velocity_estimator.sv
// rtl/wheel_velocity_estimator.sv - four-channel quadrature decoder with windowed rad/s conversion
// Per wheel: 2-flop sync, Gray-step decode, saturating window counter; one FSM converts all four serially.
module wheel_velocity_estimator #(
    parameter int N_WIDTH       = 17,
    parameter int Q_WIDTH       = 8,
    parameter int COUNT_WIDTH   = 16,
    parameter int WINDOW_CYCLES = 500000,
    parameter int SCALE_Q8      = 112
) (
    input  logic               WHEEL_VELOCITY_CLOCK_50,
    input  logic               WHEEL_VELOCITY_Reset_InHigh,
    input  logic [3:0]         WHEEL_VELOCITY_EncA_InBus,
    input  logic [3:0]         WHEEL_VELOCITY_EncB_InBus,
    output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W1_OutBus,
    output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W2_OutBus,
    output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W3_OutBus,
    output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W4_OutBus,
    output logic               WHEEL_VELOCITY_Valid_OutHigh,
    output logic [3:0]         WHEEL_VELOCITY_Error_OutBus
);
    localparam int MAG_W   = N_WIDTH - 1;
    localparam int PROD_W  = COUNT_WIDTH + 16;
    localparam int TIMER_W = $clog2(WINDOW_CYCLES);
    localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;

    if (Q_WIDTH != 8 || WINDOW_CYCLES < 8) begin : g_bad_params
        $error("wheel_velocity_estimator: Q_WIDTH must be 8 and WINDOW_CYCLES at least 8");
    end

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_PUBLISH} state_t;

    logic [3:0]                     a_meta, a_sync, a_prev;
    logic [3:0]                     b_meta, b_sync, b_prev;
    logic [1:0]                     prime_cnt;
    logic                           dec_en;
    logic [3:0]                     step_fwd, step_rev, step_bad;
    logic [TIMER_W-1:0]             win_timer;
    logic                           window_end;
    logic signed [COUNT_WIDTH-1:0]  cnt  [4];
    logic signed [COUNT_WIDTH-1:0]  snap [4];
    logic [N_WIDTH-1:0]             staged [4];
    state_t                         state;
    logic [1:0]                     ch_idx;
    logic [COUNT_WIDTH-1:0]         conv_snap, conv_abs;
    logic [PROD_W-1:0]              conv_prod;
    logic [MAG_W-1:0]               conv_mag;
    logic [N_WIDTH-1:0]             conv_word;

    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic signed [COUNT_WIDTH-1:0] count_step(
        input logic signed [COUNT_WIDTH-1:0] c, input logic fwd, input logic rev);
        if (fwd && c != CNT_MAX) return c + COUNT_WIDTH'(1);
        if (rev && c != CNT_MIN) return c - COUNT_WIDTH'(1);
        return c;
    endfunction

    assign dec_en     = (prime_cnt == 2'd3);
    assign window_end = (win_timer == TIMER_W'(WINDOW_CYCLES - 1));

    // Position difference mod 4: +1 forward, 3 reverse, 2 means both phases moved.
    always_comb begin
        step_fwd = '0;
        step_rev = '0;
        step_bad = '0;
        for (int i = 0; i < 4; i++) begin
            step_fwd[i] = dec_en && (2'(gray_pos({a_sync[i], b_sync[i]}) - gray_pos({a_prev[i], b_prev[i]})) == 2'd1);
            step_rev[i] = dec_en && (2'(gray_pos({a_sync[i], b_sync[i]}) - gray_pos({a_prev[i], b_prev[i]})) == 2'd3);
            step_bad[i] = dec_en && (2'(gray_pos({a_sync[i], b_sync[i]}) - gray_pos({a_prev[i], b_prev[i]})) == 2'd2);
        end
    end

    always_comb begin
        conv_snap = snap[ch_idx];
        conv_abs  = conv_snap[COUNT_WIDTH-1] ? (~conv_snap + COUNT_WIDTH'(1)) : conv_snap;
        conv_prod = PROD_W'(conv_abs) * PROD_W'(SCALE_Q8);
        conv_mag  = (conv_prod > PROD_W'({MAG_W{1'b1}})) ? '1 : conv_prod[MAG_W-1:0];
        conv_word = {conv_snap[COUNT_WIDTH-1] && (conv_mag != '0), conv_mag};
    end

    always_ff @(posedge WHEEL_VELOCITY_CLOCK_50) begin
        if (WHEEL_VELOCITY_Reset_InHigh) begin
            a_meta    <= '0;
            a_sync    <= '0;
            a_prev    <= '0;
            b_meta    <= '0;
            b_sync    <= '0;
            b_prev    <= '0;
            prime_cnt <= '0;
            win_timer <= '0;
            state     <= S_IDLE;
            ch_idx    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]    <= '0;
                snap[i]   <= '0;
                staged[i] <= '0;
            end
            WHEEL_VELOCITY_W1_OutBus     <= '0;
            WHEEL_VELOCITY_W2_OutBus     <= '0;
            WHEEL_VELOCITY_W3_OutBus     <= '0;
            WHEEL_VELOCITY_W4_OutBus     <= '0;
            WHEEL_VELOCITY_Valid_OutHigh <= 1'b0;
            WHEEL_VELOCITY_Error_OutBus  <= '0;
        end else begin
            a_meta <= WHEEL_VELOCITY_EncA_InBus;
            a_sync <= a_meta;
            a_prev <= a_sync;
            b_meta <= WHEEL_VELOCITY_EncB_InBus;
            b_sync <= b_meta;
            b_prev <= b_sync;
            if (!dec_en) prime_cnt <= prime_cnt + 2'd1;
            WHEEL_VELOCITY_Error_OutBus <= WHEEL_VELOCITY_Error_OutBus | step_bad;
            win_timer <= window_end ? '0 : win_timer + TIMER_W'(1);

            // A step decoded in the terminal cycle belongs to the new window.
            for (int i = 0; i < 4; i++) begin
                if (window_end) begin
                    snap[i] <= cnt[i];
                    cnt[i]  <= count_step('0, step_fwd[i], step_rev[i]);
                end else begin
                    cnt[i]  <= count_step(cnt[i], step_fwd[i], step_rev[i]);
                end
            end

            WHEEL_VELOCITY_Valid_OutHigh <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (window_end) begin
                        state  <= S_CONV;
                        ch_idx <= '0;
                    end
                end
                S_CONV: begin
                    staged[ch_idx] <= conv_word;
                    ch_idx         <= ch_idx + 2'd1;
                    if (ch_idx == 2'd3) begin
                        state                        <= S_PUBLISH;
                        WHEEL_VELOCITY_W1_OutBus     <= staged[0];
                        WHEEL_VELOCITY_W2_OutBus     <= staged[1];
                        WHEEL_VELOCITY_W3_OutBus     <= staged[2];
                        WHEEL_VELOCITY_W4_OutBus     <= conv_word;
                        WHEEL_VELOCITY_Valid_OutHigh <= 1'b1;
                    end
                end
                S_PUBLISH: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wheel_velocity_estimator.sv
// tb/tb_wheel_velocity_estimator.sv - scoreboard bench for wheel_velocity_estimator
module tb_wheel_velocity_estimator;
    localparam int WC  = 1000;
    localparam int WC2 = 4000;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [3:0]  enc_a, enc_b, enc2_a, enc2_b;
    logic [16:0] w1, w2, w3, w4, s1, s2, s3, s4;
    logic        valid, valid2;
    logic [3:0]  err, err2;

    always #5 clk = ~clk;

    wheel_velocity_estimator #(.WINDOW_CYCLES(WC)) dut (
        .WHEEL_VELOCITY_CLOCK_50(clk), .WHEEL_VELOCITY_Reset_InHigh(rst),
        .WHEEL_VELOCITY_EncA_InBus(enc_a), .WHEEL_VELOCITY_EncB_InBus(enc_b),
        .WHEEL_VELOCITY_W1_OutBus(w1), .WHEEL_VELOCITY_W2_OutBus(w2),
        .WHEEL_VELOCITY_W3_OutBus(w3), .WHEEL_VELOCITY_W4_OutBus(w4),
        .WHEEL_VELOCITY_Valid_OutHigh(valid), .WHEEL_VELOCITY_Error_OutBus(err));

    wheel_velocity_estimator #(.WINDOW_CYCLES(WC2)) dut_sat (
        .WHEEL_VELOCITY_CLOCK_50(clk), .WHEEL_VELOCITY_Reset_InHigh(rst2),
        .WHEEL_VELOCITY_EncA_InBus(enc2_a), .WHEEL_VELOCITY_EncB_InBus(enc2_b),
        .WHEEL_VELOCITY_W1_OutBus(s1), .WHEEL_VELOCITY_W2_OutBus(s2),
        .WHEEL_VELOCITY_W3_OutBus(s3), .WHEEL_VELOCITY_W4_OutBus(s4),
        .WHEEL_VELOCITY_Valid_OutHigh(valid2), .WHEEL_VELOCITY_Error_OutBus(err2));

    typedef struct {
        logic [3:0][7:0]  cnt;
        logic [3:0][16:0] w;
    } vec_t;

    typedef struct {
        int               cyc;
        logic [3:0][16:0] w;
    } exp_t;

    exp_t             sbq[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               pos [4];
    int               pos2;
    logic [3:0][16:0] last_pub = '0;
    logic             hold_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Pops one expectation per Valid and checks the buses held steady since the last one.
    always @(negedge clk) begin
        if (rst) begin
            last_pub <= '0;
            hold_bad <= 1'b0;
        end
        if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                check("valid_cycle", cyc, sbq[0].cyc);
                check("W1", 32'(w1), 32'(sbq[0].w[0]));
                check("W2", 32'(w2), 32'(sbq[0].w[1]));
                check("W3", 32'(w3), 32'(sbq[0].w[2]));
                check("W4", 32'(w4), 32'(sbq[0].w[3]));
                check("w_hold", 32'(hold_bad), 32'd0);
                void'(sbq.pop_front());
            end
            last_pub <= {w4, w3, w2, w1};
            hold_bad <= 1'b0;
        end else if (rst === 1'b0 && {w4, w3, w2, w1} !== last_pub) begin
            hold_bad <= 1'b1;
        end
    end

    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic vec_t mkvec(input int c1, input int c2, input int c3, input int c4,
                                   input logic [16:0] x1, input logic [16:0] x2,
                                   input logic [16:0] x3, input logic [16:0] x4);
        vec_t v;
        v.cnt = {8'(c4), 8'(c3), 8'(c2), 8'(c1)};
        v.w   = {x4, x3, x2, x1};
        return v;
    endfunction

    task automatic step(input int i, input bit fwd);
        logic [1:0] g;
        pos[i]   = fwd ? (pos[i] + 1) % 4 : (pos[i] + 3) % 4;
        g        = gray(pos[i]);
        enc_a[i] = g[1];
        enc_b[i] = g[0];
    endtask

    task automatic step2(input bit fwd);
        logic [1:0] g;
        pos2      = fwd ? (pos2 + 1) % 4 : (pos2 + 3) % 4;
        g         = gray(pos2);
        enc2_a[2] = g[1];
        enc2_b[2] = g[0];
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input int c, input logic [3:0][16:0] w);
        exp_t e;
        e.cyc = c;
        e.w   = w;
        sbq.push_back(e);
    endtask

    // Steps 20 clocks apart starting 10 cycles into window n; result is due at E+5.
    task automatic apply_window(input int n, input vec_t v, input bit expect_out);
        int base, maxs, c;
        base = n * WC;
        maxs = 0;
        for (int i = 0; i < 4; i++) begin
            c = int'($signed(v.cnt[i]));
            if (c < 0) c = -c;
            if (c > maxs) maxs = c;
        end
        if (expect_out) sb_push(base + WC + 4, v.w);
        for (int k = 0; k < maxs; k++) begin
            goto_cycle(base + 10 + 20 * k);
            for (int i = 0; i < 4; i++) begin
                c = int'($signed(v.cnt[i]));
                if (c > k) step(i, 1'b1);
                else if (-c > k) step(i, 1'b0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_error"}, 32'(err), 32'd0);
        check({tag, "_w"}, 32'(w1 | w2 | w3 | w4), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   lc, nv2;

        rst = 1'b1; rst2 = 1'b1;
        enc_a = '0; enc_b = '0; enc2_a = '0; enc2_b = '0;
        pos = '{0, 0, 0, 0};
        pos2 = 0;

        tbl[0] = mkvec(10, 0, 0, 0,    17'h00460, 17'h00000, 17'h00000, 17'h00000);
        tbl[1] = mkvec(0, -10, 0, 0,   17'h00000, 17'h10460, 17'h00000, 17'h00000);
        tbl[2] = mkvec(0, 0, 0, 0,     17'h00000, 17'h00000, 17'h00000, 17'h00000);
        tbl[3] = mkvec(3, -7, 25, -1,  17'h00150, 17'h10310, 17'h00AF0, 17'h10070);
        tbl[4] = mkvec(-40, 40, 1, 0,  17'h11180, 17'h01180, 17'h00070, 17'h00000);
        tbl[5] = mkvec(0, 0, 0, 0,     17'h00000, 17'h00000, 17'h00000, 17'h00000);

        @(posedge clk);
        #1;
        for (int r = 0; r < 5; r++) begin
            enc_a = 4'($urandom);
            enc_b = 4'($urandom);
            @(posedge clk);
            #1;
            check_reset_outputs("reset");
        end
        enc_a = '0;
        enc_b = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 6; n++) apply_window(n, tbl[n], 1'b1);
        goto_cycle(5500);
        check("error_clean", 32'(err), 32'd0);

        // Step decoded in E goes to the next window; one decoded at E-1 stays.
        sb_push(7 * WC + 4, {17'h00000, 17'h00000, 17'h00070, 17'h00000});
        sb_push(8 * WC + 4, {17'h00000, 17'h00000, 17'h00000, 17'h00070});
        goto_cycle(7 * WC - 4);
        step(1, 1'b1);
        goto_cycle(7 * WC - 3);
        step(0, 1'b1);

        sb_push(9 * WC + 4, '0);
        goto_cycle(8 * WC + 10);
        pos[3] = (pos[3] + 2) % 4;
        enc_a[3] = ~enc_a[3];
        enc_b[3] = ~enc_b[3];
        goto_cycle(8 * WC + 100);
        check("error_illegal", 32'(err), 32'h8);
        apply_window(9, mkvec(0, 0, 0, 5, 17'h0, 17'h0, 17'h0, 17'h00230), 1'b1);
        goto_cycle(10 * WC + 10);
        check("error_sticky", 32'(err), 32'h8);

        apply_window(10, mkvec(5, 0, 0, 0, 17'h0, 17'h0, 17'h0, 17'h0), 1'b0);
        goto_cycle(11 * WC + 1);
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("midconv_reset");
        end
        rst = 1'b0;
        apply_window(0, mkvec(0, 0, -2, 0, 17'h0, 17'h0, 17'h100E0, 17'h0), 1'b1);
        goto_cycle(WC + 10);
        check("sb_drained", sbq.size(), 32'd0);
        check("error_after_reset", 32'(err), 32'd0);
        rst = 1'b1;

        @(posedge clk);
        #1;
        rst2 = 1'b0;
        lc   = 0;
        nv2  = 0;
        while (lc < 2 * WC2 + 100) begin
            if (valid2 === 1'b1) begin
                if (nv2 == 0) begin
                    check("sat_cycle", lc, WC2 + 4);
                    check("sat_W3_pos", 32'(s3), 32'h0FFFF);
                end else begin
                    check("sat_cycle2", lc, 2 * WC2 + 4);
                    check("sat_W3_neg", 32'(s3), 32'h1FFFF);
                end
                check("sat_others", 32'(s1 | s2 | s4), 32'd0);
                nv2++;
            end
            if (lc >= 50 && lc < 50 + 6 * 600 && (lc - 50) % 6 == 0) step2(1'b1);
            else if (lc >= WC2 + 50 && lc < WC2 + 50 + 6 * 600 && (lc - WC2 - 50) % 6 == 0) step2(1'b0);
            @(posedge clk);
            #1;
            lc++;
        end
        check("sat_valid_count", nv2, 32'd2);
        check("sat_error", 32'(err2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
